// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready request and
// response channels, serviced against an internal word array after LATENCY cycles.
module dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the request side is ready only in IDLE, the response side is valid only in RESP.

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           be_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    fire;
  logic                    acc_err;
  logic [ADDR_WIDTH-3:0]   word_idx;

  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  // Out-of-range indices are errors, never aliased onto the array.
  assign acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_W);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_d = BUSY;
      end
      BUSY: begin
        fire = (cnt_q == '0);
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt_q   <= CW'(LATENCY - 1);
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (fire) begin
        err_q   <= acc_err;
        rdata_q <= (wr_q || acc_err) ? '0 : mem[word_idx[IW-1:0]];
      end
    end
  end

  // Array has no reset; a store aborted by reset never reaches fire.
  always_ff @(posedge clk) begin
    if (fire && wr_q && !acc_err) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[word_idx[IW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the CPU load/store interface. It accepts one read or write request at a time through a valid/ready handshake and services it against an internal word-addressed array after a fixed, parameterized latency. It then returns the result through a valid/ready response channel. It sits between the CPU datapath (MemRead/MemWrite, Address, Write_data, Read_data) and the data store, and replaces the zero-latency memory model.

Parameters:
ADDR_WIDTH, 32, byte address width of req_addr
DATA_WIDTH, 32, word width; fixed at 32 to match the register-file databuses (4 byte lanes)
DEPTH, 256, number of 32-bit words in the array; legal word index range is 0..DEPTH-1
LATENCY, 2, number of cycles from request acceptance to the array access; must be >= 1

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  CPU presents a request
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store (MemWrite), 0 = load (MemRead)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data
req_be  input  4  byte-lane write enables; lane i = bits [8i+7:8i]
rsp_valid  output  1  response available
rsp_ready  input  1  CPU accepts the response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  access was misaligned or out of range

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0, captured request registers=0.
  - req_ready follows state, so it reads 1 while reset is held.
  - Array contents are not reset.
  - Reset mid-transaction aborts it. A write not yet performed is never performed. No response is issued.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready: capture write, addr, wdata and be; load counter with LATENCY-1; go to BUSY.
  - BUSY: req_ready=0.
    - If counter!=0: decrement it.
    - If counter==0: perform the access, register the result into rsp_rdata/rsp_err, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_valid&rsp_ready. On that handshake: go to IDLE, rsp_valid=0.
- Latency:
  - Request accepted at edge k: rsp_valid=1 first after edge k+LATENCY.
  - If rsp_ready=1 is held, the next request can be accepted at edge k+LATENCY+2. There is no same-cycle overlap of response and new request.
- Access rules:
  - Word index = captured addr[ADDR_WIDTH-1:2].
  - Error when addr[1:0]!=0 or word index >= DEPTH. On error: no array write, rsp_rdata=0, rsp_err=1.
  - Load: rsp_rdata = array[index], rsp_err=0.
  - Store: for each i with be[i]=1, byte lane i of array[index] is replaced by wdata lane i; other lanes are unchanged. rsp_rdata=0, rsp_err=0.
  - Store with be=4'b0000: no array change; still a normal response with rsp_err=0.
- Inputs are sampled only at acceptance. req_* changes during BUSY/RESP have no effect.
- req_valid while not ready: the request is not accepted. The CPU must hold it until accepted.
- rsp_ready while rsp_valid=0: ignored.
- The address upper bits wrap nowhere: any index >= DEPTH is an error, not aliased.

Test Plan:
1. Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF; load addr=0x10 -> load rsp_rdata=0xDEADBEEF, rsp_err=0; with LATENCY=2, rsp_valid rises exactly 2 edges after acceptance.
2. After scenario 1, store addr=0x10, wdata=0x000000AA, be=4'b0001, then load -> rsp_rdata=0xDEADBEAA; store with be=0 -> data unchanged, rsp_err=0.
3. Load addr=0x12 (misaligned) and addr=DEPTH*4 (0x400) -> rsp_err=1, rsp_rdata=0; follow-up load of the target word shows no corruption.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; a second req_valid is not accepted until 1 cycle after the response handshake.
5. Assert reset low in BUSY during a store to 0x20 (previously 0x11111111) -> no response is issued, req_ready=1 after release, load 0x20 returns 0x11111111.
6. LATENCY=1 build: back-to-back load stream with rsp_ready=1 -> one accept every 3 cycles, rsp_valid 1 edge after each accept.
